// File: rtl/j1_io_pkg.sv
// Shared definitions for the J1 I/O bus arbiter: bus width defaults and FSM encoding.
package j1_io_pkg;

    localparam int unsigned IO_DW = 16;
    localparam int unsigned IO_AW = 16;

    // Secondary-master transaction states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/j1_io_arbiter.sv
// Shares the J1 I/O bus between the CPU (absolute priority, zero latency) and one
// secondary master that is served only in cycles where the CPU issues no I/O access.
module j1_io_arbiter
    import j1_io_pkg::*;
#(
    parameter int unsigned DW = IO_DW,
    parameter int unsigned AW = IO_AW,
    parameter int unsigned SW = 8
) (
    input  logic          sys_clk_i,
    input  logic          sys_rst_i,
    // J1 CPU side
    input  logic          cpu_rd_i,
    input  logic          cpu_wr_i,
    input  logic [AW-1:0] cpu_addr_i,
    input  logic [DW-1:0] cpu_dout_i,
    output logic [DW-1:0] cpu_din_o,
    // Secondary master side
    input  logic          m1_req_i,
    input  logic          m1_we_i,
    input  logic [AW-1:0] m1_addr_i,
    input  logic [DW-1:0] m1_wdata_i,
    output logic          m1_busy_o,
    output logic          m1_ack_o,
    output logic [DW-1:0] m1_rdata_o,
    // Peripheral bus side
    output logic          io_rd_o,
    output logic          io_wr_o,
    output logic [AW-1:0] io_addr_o,
    output logic [DW-1:0] io_wdata_o,
    input  logic [DW-1:0] io_rdata_i,
    output logic          starve_o
);

    localparam logic [SW-1:0] STARVE_MAX = {SW{1'b1}};

    state_e        r_state;
    state_e        w_state_d;
    logic          r_we_h;
    logic [AW-1:0] r_addr_h;
    logic [DW-1:0] r_wdata_h;
    logic [DW-1:0] r_rdata;
    logic [SW-1:0] r_starve_cnt;

    logic          w_cpu_act;
    logic          w_m1_issue;

    assign w_cpu_act  = cpu_rd_i | cpu_wr_i;
    // The held transaction only reaches the bus on a CPU-quiet cycle outside reset
    assign w_m1_issue = (r_state == ST_PEND) && !w_cpu_act && sys_rst_i;

    assign cpu_din_o  = io_rdata_i;
    assign m1_busy_o  = (r_state != ST_IDLE);
    assign m1_ack_o   = (r_state == ST_DONE);
    assign m1_rdata_o = r_rdata;
    assign starve_o   = (r_starve_cnt == STARVE_MAX);

    // Bus mux: CPU passthrough by default, secondary master only when issuing
    always_comb begin
        io_rd_o    = cpu_rd_i;
        io_wr_o    = cpu_wr_i;
        io_addr_o  = cpu_addr_i;
        io_wdata_o = cpu_dout_i;
        if (w_m1_issue) begin
            io_rd_o    = !r_we_h;
            io_wr_o    = r_we_h;
            io_addr_o  = r_addr_h;
            io_wdata_o = r_wdata_h;
        end
    end

    // Next-state logic for the secondary transaction FSM
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            ST_IDLE: if (m1_req_i) w_state_d = ST_PEND;
            ST_PEND: if (w_m1_issue) w_state_d = ST_DONE;
            ST_DONE: w_state_d = ST_IDLE;
            default: w_state_d = ST_IDLE;
        endcase
    end

    // State, request hold registers and read-data capture
    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_i) begin
            r_state   <= ST_IDLE;
            r_we_h    <= 1'b0;
            r_addr_h  <= '0;
            r_wdata_h <= '0;
            r_rdata   <= '0;
        end else begin
            r_state <= w_state_d;
            if (r_state == ST_IDLE && m1_req_i) begin
                r_we_h    <= m1_we_i;
                r_addr_h  <= m1_addr_i;
                r_wdata_h <= m1_wdata_i;
            end
            // Writes leave the last read data in place
            if (w_m1_issue && !r_we_h) begin
                r_rdata <= io_rdata_i;
            end
        end
    end

    // Saturating count of cycles the pending transaction lost to the CPU
    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_i) begin
            r_starve_cnt <= '0;
        end else if (r_state == ST_DONE) begin
            r_starve_cnt <= '0;
        end else if (r_state == ST_PEND && w_cpu_act && r_starve_cnt != STARVE_MAX) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_j1_io_arbiter.sv
// Randomized bench for j1_io_arbiter: a transaction-level model predicts bus outputs
// each cycle and pushes expected completions into a scoreboard drained by a monitor.
module tb_j1_io_arbiter;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int SW = 3;
    localparam int STARVE_LIMIT = (1 << SW) - 1;

    logic          clk;
    logic          rst_n;
    logic          cpu_rd, cpu_wr;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_dout, cpu_din;
    logic          m1_req, m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic          m1_busy, m1_ack;
    logic          io_rd, io_wr;
    logic [AW-1:0] io_addr;
    logic [DW-1:0] io_wdata, io_rdata;
    logic          starve;

    j1_io_arbiter #(.DW(DW), .AW(AW), .SW(SW)) dut (
        .sys_clk_i  (clk),
        .sys_rst_i  (rst_n),
        .cpu_rd_i   (cpu_rd),
        .cpu_wr_i   (cpu_wr),
        .cpu_addr_i (cpu_addr),
        .cpu_dout_i (cpu_dout),
        .cpu_din_o  (cpu_din),
        .m1_req_i   (m1_req),
        .m1_we_i    (m1_we),
        .m1_addr_i  (m1_addr),
        .m1_wdata_i (m1_wdata),
        .m1_busy_o  (m1_busy),
        .m1_ack_o   (m1_ack),
        .m1_rdata_o (m1_rdata),
        .io_rd_o    (io_rd),
        .io_wr_o    (io_wr),
        .io_addr_o  (io_addr),
        .io_wdata_o (io_wdata),
        .io_rdata_i (io_rdata),
        .starve_o   (starve)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        logic [DW-1:0] rdata;
    } exp_ack_t;

    exp_ack_t sb[$];
    int total = 0;
    int bad   = 0;
    int n_acks = 0;

    // Transaction-level model: no transaction, one waiting for a quiet bus, or one completing
    typedef enum int {TxnNone, TxnWaiting, TxnCompleting} txn_e;
    txn_e          m_txn = TxnNone;
    int            m_blocked = 0;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_last_rdata = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Monitor: every completion pulse must match the oldest predicted completion
    always @(negedge clk) begin
        if (m1_ack === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL ack_unexpected cycle=%0d got=ack expected=no ack", cyc);
            end else begin
                exp_ack_t e;
                e = sb.pop_front();
                check("ack_cycle", cyc, e.cyc);
                check("ack_rdata", {16'h0, m1_rdata}, {16'h0, e.rdata});
                n_acks++;
            end
        end
    end

    task automatic run(input int n, input bit rst_v, input int cpu_pct, input int req_pct);
        for (int i = 0; i < n; i++) begin
            bit issue;
            bit cpu_act;
            int kind;
            @(posedge clk);
            #1;
            rst_n    = rst_v;
            kind     = $urandom_range(2);
            cpu_act  = ($urandom_range(99) < cpu_pct);
            cpu_rd   = cpu_act && (kind != 1);
            cpu_wr   = cpu_act && (kind != 0);
            cpu_addr = AW'($urandom);
            cpu_dout = DW'($urandom);
            io_rdata = DW'($urandom);
            m1_req   = ($urandom_range(99) < req_pct);
            m1_we    = $urandom_range(1) == 1;
            m1_addr  = AW'($urandom);
            m1_wdata = DW'($urandom);
            issue    = rst_v && (m_txn == TxnWaiting) && !cpu_act;
            @(negedge clk);
            check("io_rd", {31'h0, io_rd}, {31'h0, issue ? !m_we : cpu_rd});
            check("io_wr", {31'h0, io_wr}, {31'h0, issue ? m_we : cpu_wr});
            check("io_addr", {16'h0, io_addr}, {16'h0, issue ? m_addr : cpu_addr});
            check("io_wdata", {16'h0, io_wdata}, {16'h0, issue ? m_wdata : cpu_dout});
            check("cpu_din", {16'h0, cpu_din}, {16'h0, io_rdata});
            check("m1_busy", {31'h0, m1_busy}, {31'h0, m_txn != TxnNone});
            check("m1_ack", {31'h0, m1_ack}, {31'h0, m_txn == TxnCompleting});
            check("m1_rdata", {16'h0, m1_rdata}, {16'h0, m_last_rdata});
            check("starve", {31'h0, starve}, {31'h0, m_blocked >= STARVE_LIMIT});
            if (cpu_act && (io_rd !== cpu_rd || io_wr !== cpu_wr)) begin
                check("cpu_priority", {31'h0, io_rd ^ io_wr}, {31'h0, cpu_rd ^ cpu_wr});
            end
            // Advance the model across the coming edge
            if (!rst_v) begin
                m_txn        = TxnNone;
                m_blocked    = 0;
                m_last_rdata = '0;
            end else begin
                case (m_txn)
                    TxnNone: begin
                        if (m1_req) begin
                            m_we    = m1_we;
                            m_addr  = m1_addr;
                            m_wdata = m1_wdata;
                            m_txn   = TxnWaiting;
                        end
                    end
                    TxnWaiting: begin
                        if (issue) begin
                            if (!m_we) m_last_rdata = io_rdata;
                            sb.push_back('{cyc: cyc + 1, rdata: m_last_rdata});
                            m_txn = TxnCompleting;
                        end else begin
                            m_blocked++;
                        end
                    end
                    default: begin
                        m_txn     = TxnNone;
                        m_blocked = 0;
                    end
                endcase
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_dout = '0;
        io_rdata = '0; m1_req = 1'b1; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
        run(3, 1'b0, 50, 100);      // reset held with requests asserted
        run(150, 1'b1, 30, 40);     // mixed traffic
        run(60, 1'b1, 90, 60);      // heavy CPU contention
        run(4, 1'b1, 0, 0);         // let any transaction finish
        run(1, 1'b1, 0, 100);       // accept a request
        run(12, 1'b1, 100, 0);      // continuous CPU: starvation saturates
        run(4, 1'b1, 0, 0);         // issue, ack, starve clears
        run(1, 1'b1, 0, 100);       // accept a request
        run(1, 1'b1, 100, 0);       // blocked in pending
        run(2, 1'b0, 0, 100);       // reset mid-operation drops it
        run(20, 1'b1, 20, 60);      // fresh requests after reset
        run(120, 1'b1, 50, 50);
        run(6, 1'b1, 0, 0);         // drain
        check("sb_drained", sb.size(), 0);
        check("acks_seen", {31'h0, n_acks >= 20}, 32'h1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
